// File: rtl/result_reader_if.sv
// result_reader_if: result-bank read port plus the ready/valid result stream.
interface result_reader_if #(
    parameter int DATA_W = 16
);
    logic [2:0]        rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    modport master (output rd_sel, dout, dout_valid, dout_last, input rd_data, dout_ready);
    modport slave (input rd_sel, dout, dout_valid, dout_last, output rd_data, dout_ready);
endinterface

// File: rtl/result_reader.sv
// result_reader: unloads NUM_RESULTS result words to a ready/valid sink, then pulses a bank clear.
module result_reader #(
    parameter int NUM_RESULTS = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    result_reader_if.master   bus,
    output logic              busy,
    output logic              output_clr,
    output logic [DATA_W-1:0] checksum
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, CLEAR} state_t;
    localparam logic [2:0] LAST = 3'(NUM_RESULTS - 1);
    state_t            state, state_nx;
    logic [2:0]        idx;
    logic [DATA_W-1:0] dout_q;
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            dout_q   <= '0;
            checksum <= '0;
        end else if (state == IDLE && start) begin
            idx      <= '0;
            checksum <= '0;
        end else if (state == FETCH) begin
            dout_q <= bus.rd_data;
        end else if (state == SEND && bus.dout_ready) begin
            checksum <= checksum + dout_q;
            if (idx != LAST) idx <= idx + 3'd1;
        end
    end
    // every output is a decode of registered state; dout_ready only steers next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = SEND;
            SEND:    state_nx = bus.dout_ready ? (idx == LAST ? CLEAR : FETCH) : SEND;
            default: state_nx = IDLE;
        endcase
        bus.rd_sel     = (state == FETCH || state == SEND) ? idx : 3'b111;
        bus.dout       = dout_q;
        bus.dout_valid = state == SEND;
        bus.dout_last  = state == SEND && idx == LAST;
        busy           = state != IDLE;
        output_clr     = state == CLEAR;
    end
endmodule
